// File: rtl/coin_tally_uart.sv
// Per-channel saturating coin counters with an 8N1 UART that sends a hex ASCII
// snapshot frame of all counts ("HH,HH,...,HH\r\n") on request or on count change.
module coin_tally_uart #(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter bit          AUTO_REPORT  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         coin_in,
  input  logic                    report_req,
  input  logic                    clr_counts,
  output logic [N_CH*CNT_W-1:0]   counts,
  output logic [N_CH-1:0]         sat,
  output logic                    tx_serial,
  output logic                    tx_active,
  output logic                    tx_done
);

  localparam int unsigned DIGITS = CNT_W / 4;
  localparam int unsigned CH_W   = $clog2(N_CH + 1);
  localparam int unsigned POS_W  = $clog2(DIGITS + 1);
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_DATA, S_STOP} state_e;

  state_e                  state_q, state_d;
  logic [N_CH-1:0]         coin_q;
  logic [N_CH-1:0]         rise_c;
  logic [N_CH*CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_CH*CNT_W-1:0]   snap_q;
  logic [N_CH-1:0]         sat_q, sat_d;
  logic                    change_c;
  logic                    pending_q, pending_d;
  logic [BAUD_W-1:0]       baud_q, baud_d;
  logic                    baud_last;
  logic [2:0]              bit_q, bit_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [POS_W-1:0]        pos_q, pos_d;
  logic [7:0]              byte_q, byte_d;
  logic [7:0]              char_c;
  logic [3:0]              nib_c;
  logic                    done_q, done_d;

  assign rise_c = coin_in & ~coin_q;

  // clr_counts wins over any increment in the same cycle; that edge is lost.
  always_comb begin
    cnt_d    = cnt_q;
    sat_d    = sat_q;
    change_c = 1'b0;
    if (clr_counts) begin
      cnt_d = '0;
      sat_d = '0;
    end else begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        if (rise_c[k]) begin
          if (cnt_q[k*CNT_W +: CNT_W] == CNT_MAX) begin
            sat_d[k] = 1'b1;
          end else begin
            cnt_d[k*CNT_W +: CNT_W] = cnt_q[k*CNT_W +: CNT_W] + CNT_W'(1);
            change_c = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (state_q == S_LOAD) pending_d = 1'b0;
    if (report_req || (AUTO_REPORT && (change_c || clr_counts))) pending_d = 1'b1;
  end

  // Character at (ch_q, pos_q): pos 0..DIGITS-1 are hex digits MSB first,
  // pos DIGITS is the separator (',' or CR on the last channel); ch_q == N_CH is LF.
  always_comb begin
    nib_c = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      for (int unsigned d = 0; d < DIGITS; d++) begin
        if (ch_q == CH_W'(c) && pos_q == POS_W'(DIGITS - 1 - d)) begin
          nib_c = snap_q[c*CNT_W + d*4 +: 4];
        end
      end
    end
    if (ch_q == CH_W'(N_CH)) begin
      char_c = 8'h0A;
    end else if (pos_q == POS_W'(DIGITS)) begin
      char_c = (ch_q == CH_W'(N_CH - 1)) ? 8'h0D : 8'h2C;
    end else if (nib_c < 4'd10) begin
      char_c = 8'h30 + {4'h0, nib_c};
    end else begin
      char_c = 8'h37 + {4'h0, nib_c};
    end
  end

  assign baud_last = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    ch_d    = ch_q;
    pos_d   = pos_q;
    byte_d  = byte_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (pending_q) state_d = S_LOAD;
      S_LOAD: begin
        state_d = S_START;
        baud_d  = '0;
        ch_d    = '0;
        pos_d   = '0;
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          byte_d  = char_c;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) state_d = S_STOP;
          else bit_d = bit_q + 3'd1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (ch_q == CH_W'(N_CH)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_START;
            if (pos_q == POS_W'(DIGITS)) begin
              pos_d = '0;
              ch_d  = ch_q + CH_W'(1);
            end else begin
              pos_d = pos_q + POS_W'(1);
            end
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      coin_q    <= '0;
      cnt_q     <= '0;
      snap_q    <= '0;
      sat_q     <= '0;
      pending_q <= 1'b0;
      baud_q    <= '0;
      bit_q     <= '0;
      ch_q      <= '0;
      pos_q     <= '0;
      byte_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      coin_q    <= coin_in;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      pending_q <= pending_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      ch_q      <= ch_d;
      pos_q     <= pos_d;
      byte_q    <= byte_d;
      done_q    <= done_d;
      if (state_q == S_LOAD) snap_q <= cnt_q;
    end
  end

  // Line is decoded from registered state so an async reset forces it high at once.
  assign tx_serial = (state_q == S_START) ? 1'b0 :
                     (state_q == S_DATA)  ? byte_q[bit_q] : 1'b1;
  assign tx_active = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
  assign tx_done   = done_q;
  assign counts    = cnt_q;
  assign sat       = sat_q;

endmodule
